// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
//   state_e      : controller states (IDLE, BUSY, DONE)
//   calc_nchunk  : number of CHUNK-wide slices in a WIDTH-bit operand
//   calc_idx_w   : width of the slice index register (at least 1 bit)
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice.
// Ports:
//   a_i, b_i  : CHUNK-bit slice operands (b already inverted for subtract)
//   cin_i     : carry into the slice
//   sum_o     : CHUNK-bit slice sum
//   cout_o    : carry out of the slice MSB
//   cmsb_o    : carry into the slice MSB (cmsb ^ cout gives signed overflow)
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    assign sum_o  = total[CHUNK-1:0];
    assign cout_o = total[CHUNK];
    // Sum bit = a ^ b ^ carry-in, so the carry entering the MSB is recoverable.
    assign cmsb_o = total[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

endmodule

// File: rtl/addsub_seq.sv
// Chunk-serial WIDTH-bit adder/subtractor with valid/ready handshakes.
// One CHUNK-bit slice is added per cycle; the result and flags are presented
// in DONE until the consumer takes them.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (a, b, sub, sat sampled on accept)
//   sub                 : 0 = a+b, 1 = a-b
//   a, b                : operands
//   sat                 : saturate on signed overflow (only with ADDSUB_SAT_EN)
//   out_valid/out_ready : result handshake
//   s, cout, ovf, zero, neg : result and status flags
// Build option: define ADDSUB_SAT_EN to add the sat port and clamping.
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | adding one slice per cycle, idx selects the slice
// DONE  | result and flags held until out_ready
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
`ifdef ADDSUB_SAT_EN
    input  logic             sat,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, bx_q, bx_d, s_q, s_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
`ifdef ADDSUB_SAT_EN
    logic               sat_q, sat_d;
`endif

    logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
    logic               c_out, c_msb;
    logic [WIDTH-1:0]   s_full;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (sum_chunk),
        .cout_o (c_out),
        .cmsb_o (c_msb)
    );

    // Slice select and write-back decoded per index to keep select widths exact.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        s_full  = s_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk                  = a_q[i*CHUNK +: CHUNK];
                b_chunk                  = bx_q[i*CHUNK +: CHUNK];
                s_full[i*CHUNK +: CHUNK] = sum_chunk;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        bx_d    = bx_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
`ifdef ADDSUB_SAT_EN
        sat_d   = sat_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    a_d     = a;
                    bx_d    = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
`ifdef ADDSUB_SAT_EN
                    sat_d   = sat;
`endif
                end
            end
            BUSY: begin
                s_d     = s_full;
                carry_d = c_out;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    cout_d  = c_out;
                    // Last slice holds the word MSB: overflow = carry-in(MSB) ^ carry-out.
                    ovf_d   = c_msb ^ c_out;
`ifdef ADDSUB_SAT_EN
                    if (sat_q && (c_msb ^ c_out)) begin
                        s_d = a_q[WIDTH-1] ? SMIN : SMAX;
                    end
`endif
                    zero_d  = (s_d == '0);
                    neg_d   = s_d[WIDTH-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
`ifdef ADDSUB_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
`ifdef ADDSUB_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign neg       = neg_q;

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, chunk-serial adder/subtractor with valid/ready handshakes and status flags. It is the successor to the 16-bit combinational add/sub unit: it processes a WIDTH-bit operation CHUNK bits per cycle. Area scales with CHUNK rather than WIDTH. The CPU execute stage instantiates it for wide or multi-cycle arithmetic, and it stalls through the handshakes.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of CHUNK.
- CHUNK, 4: bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH; NCHUNK = WIDTH/CHUNK.
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- sub  in  1  0: a+b; 1: a−b (a + ~b + 1).
- a, b  in  WIDTH  operands.
- sat  in  1  saturate on signed overflow. Present only with ADDSUB_SAT_EN.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH-1].

## Operation
- **State machine:** IDLE → BUSY → DONE → IDLE.
- **IDLE:**
  - in_ready=1.
  - On in_valid, latch a, b^{WIDTH{sub}} and sat; set carry=sub and idx=0; go to BUSY.
- **BUSY:**
  - Each cycle add chunk idx of a and bx, plus carry.
  - Write the sum into s[idx*CHUNK +: CHUNK]. Update carry. Increment idx.
  - When idx==NCHUNK-1, go to DONE and register the flags.
- **DONE:**
  - out_valid=1.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
- **Flags:**
  - ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
  - cout = final carry.
  - zero and neg are taken from the final s.
- **Width rule:**
  - Results wrap modulo 2^WIDTH.
  - No internal width exceeds CHUNK+1 bits for the chunk sum.
- **Operand timing:** Operands are sampled only at acceptance. Changes to a, b, sub or sat afterwards are ignored.
- **Result stability:** s and the flags are held stable while out_valid && !out_ready.
- **Reset:**
  - Output reset values: in_ready=1, out_valid=0, s=0, cout=ovf=zero=neg=0. State goes to IDLE.
  - Reset asserted mid-operation aborts the operation. The partial result is never presented.

## Timing
- **Acceptance:** A request is accepted on the edge where in_valid && in_ready. Call that edge E0.
- **Latency:** out_valid rises on edge E0+NCHUNK. With CHUNK=WIDTH the latency is 1 cycle.
- **Throughput:**
  - Minimum one operation per NCHUNK+2 cycles, since the next acceptance happens in IDLE.
  - in_ready is 0 throughout BUSY and DONE.
- **Back-pressure:** With out_ready held low, the unit stays in DONE indefinitely.
- **in_valid while not ready:** in_valid is ignored while in_ready=0; no request is queued.

## Configuration
- ADDSUB_SAT_EN
  - **Defined:**
    - The sat port exists.
    - When the latched sat=1 and ovf=1, s is clamped: a[MSB]=0 gives 2^(WIDTH-1)−1; a[MSB]=1 gives −2^(WIDTH-1).
    - ovf still reports 1. zero and neg reflect the clamped s. cout is unchanged.
    - The clamp is applied on the transition into DONE; latency is unchanged.
  - **Undefined:** The sat port is absent and results always wrap.

## Structure
- **Package addsub_pkg:**
  - State enum: IDLE, BUSY, DONE.
  - A function computing NCHUNK and the idx width ($clog2(NCHUNK), minimum 1).
- **Sub-module addsub_chunk:** Purely combinational CHUNK-bit adder with cin/cout and a carry-into-MSB output. It is instantiated once; the top level owns the FSM, operand/result registers and flags.

## Test plan
Defaults WIDTH=16, CHUNK=4 unless noted.
1. **Basic add:** add 0x1234+0x1111.
   - s=0x2345, cout=0, ovf=0, zero=0, neg=0.
   - out_valid exactly 4 cycles after the accept edge.
2. **Borrowing subtract:** sub 0x0005−0x0007 → s=0xFFFE, cout=0, neg=1, ovf=0.
3. **Signed overflow:** add 0x7FFF+0x0001.
   - Without the macro: s=0x8000, ovf=1, neg=1.
   - With ADDSUB_SAT_EN and sat=1: s=0x7FFF, ovf=1, neg=0.
   - Also sub 0x8000−0x0001 with sat=1 → s=0x8000, ovf=1.
4. **Equal-operand subtract:** sub 0x1234−0x1234 → s=0x0000, zero=1, cout=1.
5. **Back-pressure:**
   - Hold out_ready=0 for 5 cycles after out_valid. s and flags stay unchanged; in_ready=0; a new in_valid is ignored.
   - Release out_ready. in_ready=1 one cycle later, and the next operation completes correctly.
6. **Reset mid-operation and single-cycle configuration:**
   - Assert rst_n=0 after 2 BUSY cycles. out_valid=0 and s=0 immediately. in_ready=1 after release, and the following add 0xFFFF+0x0001 gives s=0, cout=1, zero=1.
   - Repeat the add with CHUNK=16: latency 1.
